// File: rtl/tipi_reg_write_pkg.sv
// Shared constants for the TI write-side register bank: register indices,
// default data width and the a > b > c > d select priority.
package tipi_reg_write_pkg;

   localparam int DEFAULT_WIDTH = 8;
   localparam int NUM_REGS      = 4;

   localparam int REG_A = 0;
   localparam int REG_B = 1;
   localparam int REG_C = 2;
   localparam int REG_D = 3;

   typedef logic [NUM_REGS-1:0] reg_mask_t;

   // Keeps only the lowest-indexed asserted select, matching the read-side mux.
   function automatic reg_mask_t prio_onehot(input reg_mask_t sel);
      reg_mask_t m;
      m = '0;
      for (int i = NUM_REGS - 1; i >= 0; i--) begin
         if (sel[i]) begin
            m    = '0;
            m[i] = 1'b1;
         end
      end
      return m;
   endfunction

endpackage

// File: rtl/tipi_sync_fall.sv
// Three-flop synchronizer for an active-low async strobe with a falling-edge
// pulse output. TIPI_WRITE_GLITCH_FILTER_EN requires two low samples and registers the pulse.
module tipi_sync_fall (
   input  logic clk,
   input  logic reset_n,
   input  logic async_n,
   output logic fall
);

   logic s1_reg;
   logic s2_reg;
   logic s3_reg;

   // Reset to 0 so a strobe already low at reset must go high again before it counts.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         s1_reg <= 1'b0;
         s2_reg <= 1'b0;
         s3_reg <= 1'b0;
      end else begin
         s1_reg <= async_n;
         s2_reg <= s1_reg;
         s3_reg <= s2_reg;
      end
   end

`ifdef TIPI_WRITE_GLITCH_FILTER_EN
   logic fall_reg;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         fall_reg <= 1'b0;
      end else begin
         fall_reg <= s3_reg & ~s2_reg & ~s1_reg;
      end
   end

   assign fall = fall_reg;
`else
   assign fall = s3_reg & ~s2_reg;
`endif

endmodule

// File: rtl/tipi_reg_write.sv
// TI bus write-side register bank: four latch registers, pending flags with ack,
// and a write pulse. Optional macro TIPI_WRITE_GLITCH_FILTER_EN filters we_n glitches.
module tipi_reg_write
   import tipi_reg_write_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             we_n,
   input  logic             a_addr,
   input  logic             b_addr,
   input  logic             c_addr,
   input  logic             d_addr,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] a,
   output logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] c,
   output logic [WIDTH-1:0] d,
   output logic [3:0]       pending,
   input  logic [3:0]       ack,
   output logic             wr_pulse
);

   logic             write_event;
   reg_mask_t        sel_s1_reg;
   reg_mask_t        sel_s2_reg;
   logic [WIDTH-1:0] din_s1_reg;
   logic [WIDTH-1:0] din_s2_reg;
   reg_mask_t        wr_mask;
   reg_mask_t        pending_reg;
   logic             wr_pulse_reg;
   logic [WIDTH-1:0] reg_q [NUM_REGS];

   tipi_sync_fall u_we_sync (
      .clk     (clk),
      .reset_n (reset_n),
      .async_n (we_n),
      .fall    (write_event)
   );

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         sel_s1_reg <= '0;
         sel_s2_reg <= '0;
         din_s1_reg <= '0;
         din_s2_reg <= '0;
      end else begin
         sel_s1_reg <= {d_addr, c_addr, b_addr, a_addr};
         sel_s2_reg <= sel_s1_reg;
         din_s1_reg <= din;
         din_s2_reg <= din_s1_reg;
      end
   end

   assign wr_mask = write_event ? prio_onehot(sel_s2_reg) : '0;

   for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
      logic [WIDTH-1:0] data_reg;

      always_ff @(posedge clk) begin
         if (!reset_n) begin
            data_reg <= '0;
         end else if (wr_mask[gi]) begin
            data_reg <= din_s2_reg;
         end
      end

      assign reg_q[gi] = data_reg;
   end

   // A new write beats a simultaneous ack so the Pi never misses it.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         pending_reg  <= '0;
         wr_pulse_reg <= 1'b0;
      end else begin
         pending_reg  <= (pending_reg & ~ack) | wr_mask;
         wr_pulse_reg <= |wr_mask;
      end
   end

   assign a        = reg_q[REG_A];
   assign b        = reg_q[REG_B];
   assign c        = reg_q[REG_C];
   assign d        = reg_q[REG_D];
   assign pending  = pending_reg;
   assign wr_pulse = wr_pulse_reg;

endmodule

// File: tb/tb_tipi_reg_write.sv
// Directed and randomized checks of tipi_reg_write against a register/pending
// model; inputs change on the falling clock edge, outputs are sampled there too.
module tb_tipi_reg_write;

   localparam int W = 8;
`ifdef TIPI_WRITE_GLITCH_FILTER_EN
   localparam int LAT   = 3;
   localparam int MIN_LOW = 4;
`else
   localparam int LAT   = 2;
   localparam int MIN_LOW = 3;
`endif

   logic         clk = 1'b0;
   logic         reset_n = 1'b0;
   logic         we_n = 1'b0;
   logic         a_addr = 1'b0, b_addr = 1'b0, c_addr = 1'b0, d_addr = 1'b0;
   logic [W-1:0] din = '0;
   logic [W-1:0] a, b, c, d;
   logic [3:0]   pending;
   logic [3:0]   ack = '0;
   logic         wr_pulse;

   int tests = 0;
   int fails = 0;
   int pulse_cnt = 0;

   logic [W-1:0] m_reg [4];
   logic [3:0]   m_pend;

   tipi_reg_write #(.WIDTH(W)) dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .we_n     (we_n),
      .a_addr   (a_addr),
      .b_addr   (b_addr),
      .c_addr   (c_addr),
      .d_addr   (d_addr),
      .din      (din),
      .a        (a),
      .b        (b),
      .c        (c),
      .d        (d),
      .pending  (pending),
      .ack      (ack),
      .wr_pulse (wr_pulse)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (wr_pulse === 1'b1) pulse_cnt++;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag);
      check({tag, ".a"}, {24'd0, a}, {24'd0, m_reg[0]});
      check({tag, ".b"}, {24'd0, b}, {24'd0, m_reg[1]});
      check({tag, ".c"}, {24'd0, c}, {24'd0, m_reg[2]});
      check({tag, ".d"}, {24'd0, d}, {24'd0, m_reg[3]});
      check({tag, ".pending"}, {28'd0, pending}, {28'd0, m_pend});
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic set_sel(input logic [3:0] sel);
      {d_addr, c_addr, b_addr, a_addr} = sel;
   endtask

   // Reference behaviour: the first asserted select (a first) takes the data.
   task automatic model_write(input logic [3:0] sel, input logic [W-1:0] data, output int npulse);
      npulse = 0;
      for (int i = 0; i < 4; i++) begin
         if (sel[i]) begin
            m_reg[i]  = data;
            m_pend[i] = 1'b1;
            npulse    = 1;
            break;
         end
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 4; i++) m_reg[i] = '0;
      m_pend = '0;
   endtask

   task automatic write(input string tag, input logic [3:0] sel, input logic [W-1:0] data,
                        input int lowc);
      int p0;
      int np;
      p0 = pulse_cnt;
      set_sel(sel);
      din = data;
      cyc(2);
      we_n = 1'b0;
      cyc(lowc);
      we_n = 1'b1;
      cyc(4);
      set_sel(4'b0000);
      np = 0;
      if (lowc >= MIN_LOW) model_write(sel, data, np);
      check({tag, ".pulses"}, pulse_cnt - p0, np);
      check_all(tag);
      $display("[TB] write %s sel=%b din=0x%02h low=%0d -> a=%02h b=%02h c=%02h d=%02h pend=%b",
               tag, sel, data, lowc, a, b, c, d, pending);
   endtask

   task automatic ack_pulse(input string tag, input logic [3:0] mask);
      ack = mask;
      cyc(1);
      ack = '0;
      m_pend = m_pend & ~mask;
      check({tag, ".pending"}, {28'd0, pending}, {28'd0, m_pend});
      $display("[TB] ack %s mask=%b -> pend=%b", tag, mask, pending);
   endtask

   initial begin
      int p0;
      logic [3:0] rsel;
      logic [W-1:0] rdata;

      // Reset with we_n already low: nothing may commit afterwards until it toggles.
      model_reset();
      cyc(2);
      reset_n = 1'b1;
      p0 = pulse_cnt;
      check_all("reset");
      check("reset.wr_pulse", {31'd0, wr_pulse}, 32'd0);
      cyc(6);
      check("reset.no_pulse", pulse_cnt - p0, 0);
      we_n = 1'b1;
      cyc(4);

      // Single write to b with exact latency check.
      set_sel(4'b0010);
      din = 8'h5A;
      cyc(2);
      we_n = 1'b0;
      cyc(LAT);
      check("lat.b_before", {24'd0, b}, 32'h00);
      check("lat.pulse_before", {31'd0, wr_pulse}, 32'd0);
      cyc(1);
      check("lat.b_after", {24'd0, b}, 32'h5A);
      check("lat.pulse_high", {31'd0, wr_pulse}, 32'd1);
      cyc(1);
      check("lat.pulse_low", {31'd0, wr_pulse}, 32'd0);
      we_n = 1'b1;
      cyc(4);
      set_sel(4'b0000);
      m_reg[1] = 8'h5A;
      m_pend   = 4'b0010;
      check_all("single");
      $display("[TB] write single sel=0010 din=0x5a -> b=%02h pend=%b", b, pending);

      ack_pulse("clear_all", 4'hF);
      write("priority", 4'b0101, 8'h3C, 4);
      write("nosel", 4'b0000, 8'hFF, 4);
      ack_pulse("ack_a", 4'b0001);
      write("same_val", 4'b0010, 8'h5A, 4);
      ack_pulse("ack_nonpend", 4'b0100);

      // Pending[3] set beforehand so an ack-wins fault would clear it.
      write("d_pre", 4'b1000, 8'h10, 4);
      set_sel(4'b1000);
      din = 8'h81;
      cyc(2);
      we_n = 1'b0;
      cyc(LAT);
      ack = 4'b1000;
      cyc(1);
      ack = '0;
      m_reg[3]  = 8'h81;
      m_pend[3] = 1'b1;
      check("collide.d", {24'd0, d}, 32'h81);
      check("collide.pend3", {31'd0, pending[3]}, 32'd1);
      cyc(2);
      we_n = 1'b1;
      cyc(4);
      set_sel(4'b0000);
      check_all("collide");
      $display("[TB] collide d=0x%02h pend=%b", d, pending);
      ack_pulse("ack_d", 4'b1000);

`ifdef TIPI_WRITE_GLITCH_FILTER_EN
      write("glitch", 4'b1000, 8'h77, 1);
`else
      write("glitch", 4'b1000, 8'h77, 3);
`endif

      for (int i = 0; i < 20; i++) begin
         rsel  = 4'($urandom_range(0, 15));
         rdata = 8'($urandom);
         write($sformatf("rand%0d", i), rsel, rdata, int'($urandom_range(MIN_LOW, 6)));
         if ($urandom_range(0, 1) == 1) ack_pulse($sformatf("rack%0d", i), 4'($urandom_range(0, 15)));
      end

      // Reset in the middle of a write: the write is dropped.
      set_sel(4'b0001);
      din = 8'hEE;
      cyc(2);
      we_n = 1'b0;
      reset_n = 1'b0;
      cyc(2);
      reset_n = 1'b1;
      model_reset();
      p0 = pulse_cnt;
      cyc(6);
      check("midreset.no_pulse", pulse_cnt - p0, 0);
      check_all("midreset");
      we_n = 1'b1;
      cyc(4);
      write("recover", 4'b0001, 8'h11, 4);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
